// File: rtl/attempt_tracker.sv
// attempt_tracker: counts failed password attempts while a user is present,
// enforces a lockout after the third failure and clears the count on a
// successful entry or after a sustained absence.
module attempt_tracker #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned ABSENT_CYCLES = 50_000_000,
    parameter int unsigned LOCK_CYCLES   = 500_000_000,
    parameter int unsigned CNT_W         = 29
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       presence,
    input  logic       fail,
    input  logic       pass,
    output logic [1:0] attempts,
    output logic       locked,
    output logic       present_sync
);

    localparam logic [CNT_W-1:0] ABSENT_LAST = CNT_W'(ABSENT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [63:0]      CNT_SPAN    = 64'd1 << CNT_W;
    localparam logic [1:0]       ATT_MAX     = 2'd3;

    // Elaboration-time sanity checks on the parameter set
    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("attempt_tracker: SYNC_STAGES must be at least 2");
        end
        if ((ABSENT_CYCLES == 0) || (LOCK_CYCLES == 0)) begin : g_bad_zero
            $error("attempt_tracker: ABSENT_CYCLES and LOCK_CYCLES must be non-zero");
        end
        if ((64'(ABSENT_CYCLES) > CNT_SPAN) || (64'(LOCK_CYCLES) > CNT_SPAN)) begin : g_bad_width
            $error("attempt_tracker: CNT_W too narrow for ABSENT_CYCLES/LOCK_CYCLES");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_fail_q;
    logic                   r_pass_q;
    logic [CNT_W-1:0]       r_timer;
    logic [CNT_W-1:0]       w_timer_nxt;
    logic [CNT_W-1:0]       r_absent;
    logic [CNT_W-1:0]       w_absent_nxt;
    logic [1:0]             r_attempts;
    logic [1:0]             w_attempts_nxt;
    logic                   r_locked;
    logic                   w_locked_nxt;

    logic w_present;
    logic w_fail_rise;
    logic w_pass_rise;
    logic w_lock_done;

    assign w_present    = r_sync[SYNC_STAGES-1];
    assign w_fail_rise  = fail & ~r_fail_q;
    assign w_pass_rise  = pass & ~r_pass_q;
    assign w_lock_done  = (r_timer == LOCK_LAST);

    assign attempts     = r_attempts;
    assign locked       = r_locked;
    assign present_sync = w_present;

    // Presence synchronizer and fail/pass edge-detect history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync   <= '0;
            r_fail_q <= 1'b0;
            r_pass_q <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], presence};
            r_fail_q <= fail;
            r_pass_q <= pass;
        end
    end

    // State, timers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_absent   <= '0;
            r_attempts <= 2'd0;
            r_locked   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_absent   <= w_absent_nxt;
            r_attempts <= w_attempts_nxt;
            r_locked   <= w_locked_nxt;
        end
    end

    // Next-state, timer and attempt-count decode
    always_comb begin
        w_state_nxt    = r_state;
        w_timer_nxt    = r_timer;
        w_absent_nxt   = r_absent;
        w_attempts_nxt = r_attempts;

        case (r_state)
            S_IDLE: begin
                if (w_present) begin
                    w_state_nxt = S_ARMED;
                    w_timer_nxt = '0;
                end
            end

            S_ARMED: begin
                // Timer tracks consecutive absent cycles; any present cycle restarts it
                if (w_present) begin
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + CNT_W'(1);
                end

                if (!w_present && (r_timer == ABSENT_LAST)) begin
                    w_attempts_nxt = 2'd0;
                    w_timer_nxt    = '0;
                    w_state_nxt    = S_IDLE;
                end else if (w_pass_rise) begin
                    w_attempts_nxt = 2'd0;
                end else if (w_fail_rise && (r_attempts != ATT_MAX)) begin
                    w_attempts_nxt = r_attempts + 2'd1;
                    if (r_attempts == (ATT_MAX - 2'd1)) begin
                        w_state_nxt  = S_LOCKED;
                        w_timer_nxt  = '0;
                        w_absent_nxt = '0;
                    end
                end
            end

            S_LOCKED: begin
                // Lock timer saturates at its last value, which marks lock_done
                if (!w_lock_done) begin
                    w_timer_nxt = r_timer + CNT_W'(1);
                end

                // Absence only counts once the lock has expired
                if (w_present || !w_lock_done) begin
                    w_absent_nxt = '0;
                end else if (r_absent == ABSENT_LAST) begin
                    w_attempts_nxt = 2'd0;
                    w_timer_nxt    = '0;
                    w_absent_nxt   = '0;
                    w_state_nxt    = S_IDLE;
                end else begin
                    w_absent_nxt = r_absent + CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt    = S_IDLE;
                w_timer_nxt    = '0;
                w_absent_nxt   = '0;
                w_attempts_nxt = 2'd0;
            end
        endcase

        w_locked_nxt = (w_state_nxt == S_LOCKED);
    end

endmodule

// File: tb/tb_attempt_tracker.sv
// Testbench for attempt_tracker: table-driven main sequence plus directed
// sequences for lock exit, absence boundary, persistent lock and async reset.
module tb_attempt_tracker;

    localparam int unsigned SYNC_STAGES   = 2;
    localparam int unsigned ABSENT_CYCLES = 8;
    localparam int unsigned LOCK_CYCLES   = 20;
    localparam int unsigned CNT_W         = 8;
    localparam int          N_VEC         = 32;
    // Edges after the locking edge at which the lock exits when absent:
    // lock_done after LOCK_CYCLES-1 edges, then ABSENT_CYCLES absent edges.
    localparam int          EXIT_EDGE     = 27;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       presence = 1'b0;
    logic       fail     = 1'b0;
    logic       pass     = 1'b0;
    logic [1:0] attempts;
    logic       locked;
    logic       present_sync;

    int n_run  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic       p;
        logic       f;
        logic       s;
        logic [1:0] att;
        logic       lk;
    } vec_t;

    vec_t tbl [N_VEC];

    attempt_tracker #(
        .SYNC_STAGES   (SYNC_STAGES),
        .ABSENT_CYCLES (ABSENT_CYCLES),
        .LOCK_CYCLES   (LOCK_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .presence     (presence),
        .fail         (fail),
        .pass         (pass),
        .attempts     (attempts),
        .locked       (locked),
        .present_sync (present_sync)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic p, input logic f, input logic s,
                                input logic [1:0] att, input logic lk);
        vec_t v;
        v.p   = p;
        v.f   = f;
        v.s   = s;
        v.att = att;
        v.lk  = lk;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_pulse();
        fail = 1'b1;
        tick();
        fail = 1'b0;
        tick();
    endtask

    initial begin
        logic prev_p;

        // Main sequence: idle, counting, pass clear, held fail, simultaneous, lockout
        tbl[0]  = mk(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
        tbl[1]  = mk(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        tbl[2]  = mk(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
        tbl[3]  = mk(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        tbl[4]  = mk(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        tbl[5]  = mk(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        tbl[6]  = mk(1'b1, 1'b1, 1'b0, 2'd1, 1'b0);
        tbl[7]  = mk(1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
        tbl[8]  = mk(1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
        tbl[9]  = mk(1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
        tbl[10] = mk(1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
        tbl[11] = mk(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        tbl[12] = mk(1'b1, 1'b1, 1'b0, 2'd1, 1'b0);
        tbl[13] = mk(1'b1, 1'b1, 1'b0, 2'd1, 1'b0);
        tbl[14] = mk(1'b1, 1'b1, 1'b0, 2'd1, 1'b0);
        tbl[15] = mk(1'b1, 1'b1, 1'b0, 2'd1, 1'b0);
        tbl[16] = mk(1'b1, 1'b1, 1'b0, 2'd1, 1'b0);
        tbl[17] = mk(1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
        tbl[18] = mk(1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
        tbl[19] = mk(1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
        tbl[20] = mk(1'b1, 1'b1, 1'b1, 2'd0, 1'b0);
        tbl[21] = mk(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        tbl[22] = mk(1'b1, 1'b1, 1'b0, 2'd1, 1'b0);
        tbl[23] = mk(1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
        tbl[24] = mk(1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
        tbl[25] = mk(1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
        tbl[26] = mk(1'b1, 1'b1, 1'b0, 2'd3, 1'b1);
        tbl[27] = mk(1'b1, 1'b0, 1'b0, 2'd3, 1'b1);
        tbl[28] = mk(1'b1, 1'b1, 1'b0, 2'd3, 1'b1);
        tbl[29] = mk(1'b1, 1'b0, 1'b0, 2'd3, 1'b1);
        tbl[30] = mk(1'b1, 1'b0, 1'b1, 2'd3, 1'b1);
        tbl[31] = mk(1'b1, 1'b0, 1'b0, 2'd3, 1'b1);

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check("reset_attempts", attempts, 2'd0);
        check("reset_locked", {1'b0, locked}, 2'd0);
        check("reset_present_sync", {1'b0, present_sync}, 2'd0);
        tick();
        rst_n = 1'b1;

        // Table-driven main sequence
        prev_p = 1'b0;
        for (int i = 0; i < N_VEC; i++) begin
            presence = tbl[i].p;
            fail     = tbl[i].f;
            pass     = tbl[i].s;
            tick();
            check($sformatf("row%0d_attempts", i), attempts, tbl[i].att);
            check($sformatf("row%0d_locked", i), {1'b0, locked}, {1'b0, tbl[i].lk});
            check($sformatf("row%0d_present_sync", i), {1'b0, present_sync}, {1'b0, prev_p});
            prev_p = tbl[i].p;
        end
        fail = 1'b0;
        pass = 1'b0;

        // Lock exit: locking edge was row 26, rows 27..31 are edges 1..5; drop presence at edge 6
        presence = 1'b0;
        for (int k = 6; k <= EXIT_EDGE + 3; k++) begin
            tick();
            check($sformatf("lockexit_e%0d_locked", k), {1'b0, locked},
                  (k < EXIT_EDGE) ? 2'd1 : 2'd0);
            check($sformatf("lockexit_e%0d_attempts", k), attempts,
                  (k < EXIT_EDGE) ? 2'd3 : 2'd0);
        end

        // Absence boundary: arm with attempts=2, then 7 absent cycles must not clear
        presence = 1'b1;
        repeat (4) tick();
        fail_pulse();
        fail_pulse();
        check("absent7_pre", attempts, 2'd2);
        presence = 1'b0;
        repeat (ABSENT_CYCLES - 1) tick();
        presence = 1'b1;
        repeat (5) tick();
        check("absent7_post", attempts, 2'd2);
        check("absent7_locked", {1'b0, locked}, 2'd0);

        // Absence boundary: 8 absent cycles clear (absence reaches the FSM 2 edges late)
        presence = 1'b0;
        repeat (9) tick();
        check("absent8_edge9", attempts, 2'd2);
        tick();
        check("absent8_edge10", attempts, 2'd0);
        fail_pulse();
        check("absent8_idle_ignores_fail", attempts, 2'd0);

        // Persistent presence keeps the lock indefinitely
        presence = 1'b1;
        repeat (4) tick();
        fail_pulse();
        fail_pulse();
        fail = 1'b1;
        tick();
        check("relock_attempts", attempts, 2'd3);
        check("relock_locked", {1'b0, locked}, 2'd1);
        fail = 1'b0;
        repeat (60) tick();
        check("stay_locked", {1'b0, locked}, 2'd1);
        check("stay_attempts", attempts, 2'd3);

        // Asynchronous reset between clock edges while locked
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_attempts", attempts, 2'd0);
        check("async_rst_locked", {1'b0, locked}, 2'd0);
        check("async_rst_present_sync", {1'b0, present_sync}, 2'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_attempts", attempts, 2'd0);
        check("post_rst_locked", {1'b0, locked}, 2'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
